// File: rtl/audio_clock_sequencer.sv
// Audio bit/word clock generator: runtime-selectable bclk divisor with glitch-free
// start, drain-to-frame-boundary stop and frame-aligned sample-rate changes.
module audio_clock_sequencer #(
  parameter int unsigned DIV0           = 4,
  parameter int unsigned DIV1           = 8,
  parameter int unsigned DIV2           = 16,
  parameter int unsigned DIV3           = 32,
  parameter int unsigned BCLK_PER_FRAME = 64
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] rate_sel,
  input  logic       rate_req,
  output logic       rate_busy,
  output logic       rate_ack,
  output logic       running,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_rise,
  output logic       bclk_fall,
  output logic       frame_start
);

  localparam int unsigned DIV01   = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned DIV23   = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned DIV_MAX = (DIV01 > DIV23) ? DIV01 : DIV23;
  localparam int unsigned HW      = $clog2(DIV_MAX + 1);
  localparam int unsigned BW      = $clog2(BCLK_PER_FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [HW-1:0]   half_cnt_q, half_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            pending_q, pending_d;
  logic [1:0]      pending_sel_q, pending_sel_d;
  logic            bclk_d, lrclk_d, running_d;
  logic            bclk_rise_d, bclk_fall_d, frame_start_d, rate_ack_d;

  function automatic logic [HW-1:0] div_lookup(input logic [1:0] sel);
    case (sel)
      2'd0:    return HW'(DIV0);
      2'd1:    return HW'(DIV1);
      2'd2:    return HW'(DIV2);
      default: return HW'(DIV3);
    endcase
  endfunction

  // State and all output registers
  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      h_q           <= HW'(DIV0);
      half_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      pending_q     <= 1'b0;
      pending_sel_q <= 2'd0;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      running       <= 1'b0;
      bclk_rise     <= 1'b0;
      bclk_fall     <= 1'b0;
      frame_start   <= 1'b0;
      rate_ack      <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      half_cnt_q    <= half_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pending_q     <= pending_d;
      pending_sel_q <= pending_sel_d;
      bclk          <= bclk_d;
      lrclk         <= lrclk_d;
      running       <= running_d;
      bclk_rise     <= bclk_rise_d;
      bclk_fall     <= bclk_fall_d;
      frame_start   <= frame_start_d;
      rate_ack      <= rate_ack_d;
    end
  end

  assign rate_busy = pending_q;

  // Next-state, counters and strobes
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    half_cnt_d    = half_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    pending_d     = pending_q;
    pending_sel_d = pending_sel_q;
    bclk_d        = bclk;
    lrclk_d       = lrclk;
    running_d     = 1'b0;
    bclk_rise_d   = 1'b0;
    bclk_fall_d   = 1'b0;
    frame_start_d = 1'b0;
    rate_ack_d    = 1'b0;

    if (rate_req && !pending_q) begin
      pending_d     = 1'b1;
      pending_sel_d = rate_sel;
    end

    case (state_q)
      IDLE: begin
        bclk_d     = 1'b0;
        lrclk_d    = 1'b0;
        half_cnt_d = '0;
        bit_cnt_d  = '0;
        if (pending_q) begin
          h_d        = div_lookup(pending_sel_q);
          pending_d  = 1'b0;
          rate_ack_d = 1'b1;
        end
        if (enable) begin
          state_d       = RUN;
          running_d     = 1'b1;
          frame_start_d = 1'b1;
        end
      end

      RUN, DRAIN: begin
        running_d = 1'b1;
        if (state_q == RUN && !enable) state_d = DRAIN;
        if (half_cnt_q == h_q - HW'(1)) begin
          half_cnt_d = '0;
          bclk_d     = ~bclk;
          if (!bclk) begin
            bclk_rise_d = 1'b1;
          end else begin
            bclk_fall_d = 1'b1;
            bit_cnt_d   = (bit_cnt_q == BW'(BCLK_PER_FRAME - 1)) ? '0 : bit_cnt_q + BW'(1);
            lrclk_d     = (bit_cnt_d >= BW'(BCLK_PER_FRAME / 2));
            if (bit_cnt_d == '0) begin
              frame_start_d = 1'b1;
              // Rate changes only land on a frame boundary so no half-period is cut short
              if (pending_q) begin
                h_d        = div_lookup(pending_sel_q);
                pending_d  = 1'b0;
                rate_ack_d = 1'b1;
              end
              if (state_q == DRAIN) begin
                state_d       = IDLE;
                running_d     = 1'b0;
                lrclk_d       = 1'b0;
                frame_start_d = 1'b0;
              end
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + HW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/audio_clock_sequencer.md
# audio_clock_sequencer

Generates the audio serial-bus bit clock (bclk), word-select clock (lrclk) and per-edge/per-frame strobes from the single fabric clock. The bit-clock divisor is selectable at runtime from a four-entry table. It sequences start, stop and sample-rate changes so that bclk/lrclk never glitch and frames are never truncated. It sits between the system clock and the serializer/deserializer blocks, which consume the strobes as clock enables.

## Interface

Parameters:
- DIV0, 4: bclk half-period in in_clk cycles for rate_sel=0 (reset rate); must be >=1.
- DIV1, 8: half-period for rate_sel=1; >=1.
- DIV2, 16: half-period for rate_sel=2; >=1.
- DIV3, 32: half-period for rate_sel=3; >=1.
- BCLK_PER_FRAME, 64: bclk periods per lrclk frame; even, >=2.

Ports:
- in_clk  in  1  fabric clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; request to run the clocks.
- rate_sel  in  2  divisor table index, sampled with rate_req.
- rate_req  in  1  single-cycle request to change rate.
- rate_busy  out  1  a rate request is pending; new rate_req ignored while high.
- rate_ack  out  1  one-cycle pulse: pending rate now in effect.
- running  out  1  high in RUN and DRAIN.
- bclk  out  1  bit clock, registered.
- lrclk  out  1  word select, registered; 0 = left half.
- bclk_rise  out  1  high in the cycle bclk becomes 1.
- bclk_fall  out  1  high in the cycle bclk becomes 0.
- frame_start  out  1  high in the cycle bit_cnt becomes 0.

## Operation

- State: IDLE, RUN, DRAIN. Internal registers: active half-period H; half_cnt (width $clog2 of max DIVn + 1); bit_cnt (width $clog2(BCLK_PER_FRAME)); pending flag plus pending_sel.
- IDLE: bclk=0, lrclk=0, running=0, no strobes. If enable=1, go to RUN. In the first RUN cycle: running=1, half_cnt=0, bit_cnt=0, frame_start=1.
- RUN/DRAIN counting: half_cnt increments each cycle. When half_cnt==H-1: half_cnt<=0 and bclk toggles. Rising toggle asserts bclk_rise.
- Falling toggle:
  - asserts bclk_fall;
  - bit_cnt <= (bit_cnt==BCLK_PER_FRAME-1) ? 0 : bit_cnt+1;
  - lrclk <= (new bit_cnt >= BCLK_PER_FRAME/2);
  - frame_start <= (new bit_cnt==0).
- Frame boundary: the falling toggle where the new bit_cnt is 0.
- RUN with enable=0: go to DRAIN. Counting continues.
- DRAIN: at the frame boundary go to IDLE. bclk, lrclk and running are 0 in the next cycle; no frame_start. enable going high again during DRAIN does not abort the drain. IDLE then re-enters RUN after one IDLE cycle.
- Rate change:
  - rate_req with pending=0 latches rate_sel and sets pending/rate_busy next cycle.
  - In IDLE: applied the cycle after latching; H<=DIVsel, rate_ack=1, pending cleared.
  - In RUN/DRAIN: applied at the next frame boundary; the new H is used from the following cycle, and rate_ack is asserted that cycle.
  - rate_req while pending=1, including the apply cycle, is dropped.
- Reset: the cycle after rst is sampled high, state=IDLE, H=DIV0, pending=0, and all outputs are 0. This applies mid-frame too; there is no drain.

## Timing

- Strobe latency: all outputs are registered, and each strobe coincides with the output edge it marks.
- bclk period: 2H in_clk cycles, 50% duty, including H=1 (toggles every cycle).
- Frame length: 2·H·BCLK_PER_FRAME cycles. lrclk changes only with bclk falling.
- Enable to first bclk_rise: enable sampled in IDLE, then RUN the next cycle, then bclk_rise H cycles later.
- Rate switch: occurs exactly at a frame boundary. The first half-period of the new frame uses the new H. No bclk pulse has length differing from the old or new H.

## Test plan

- Basic run: DIV0=2, BCLK_PER_FRAME=8, enable=1 after reset -> bclk period 4 cycles; frame_start every 32 cycles; lrclk high for bit_cnt 4..7; first bclk_rise 2 cycles after running rises.
- Rate change mid-frame: rate_sel=1 (DIV1=8), rate_req at bit_cnt=3 -> rate_busy high until the boundary; rate_ack coincides with frame_start; next frame is 128 cycles; second rate_req during busy is dropped.
- Stop/drain: enable=0 at bit_cnt=2 -> running stays high to the frame boundary; then bclk=lrclk=running=0; no truncated lrclk half.
- Re-enable during DRAIN -> drain completes, one IDLE cycle, then a fresh frame_start.
- Rate request in IDLE with rate_sel=3 -> rate_ack one cycle after latching; the subsequent run has bclk period 64.
- Reset mid-frame: rst at bit_cnt=5 -> all outputs 0 the next cycle; H back to DIV0; pending cleared.
- H=1 edge case: DIV0=1 -> bclk toggles every cycle; bclk_rise and bclk_fall alternate each cycle.
